// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing a single N-bit adder among NUM_REQ requesters.
// The winner's sum is registered and returned with its ID over a valid/ready channel.
module adder_share_arbiter #(
    parameter int N          = 32,
    parameter int NUM_REQ    = 4,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*N-1:0]   req_ip1,
    input  logic [NUM_REQ*N-1:0]   req_ip2,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   res_valid,
    output logic [N-1:0]           res_out,
    output logic [ID_W-1:0]        res_id,
    input  logic                   res_ready
);

    logic [NUM_REQ-1:0][N-1:0] ip1_arr, ip2_arr;
    logic [ID_W-1:0]           rr_ptr, grant_idx, next_ptr;
    logic [ID_W:0]             idx_w;
    logic                      grant_found, can_accept, accept;
    logic [N-1:0]              sum;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign ip1_arr[i] = req_ip1[i*N +: N];
        assign ip2_arr[i] = req_ip2[i*N +: N];
    end

    assign can_accept = !res_valid || res_ready;

    // Scan from rr_ptr upward with wrap; first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx_w       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_w = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx_w >= (ID_W+1)'(NUM_REQ))
                idx_w = idx_w - (ID_W+1)'(NUM_REQ);
            if (!grant_found && req_valid[idx_w[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = idx_w[ID_W-1:0];
            end
        end
    end

    assign accept   = can_accept && grant_found;
    assign sum      = ip1_arr[grant_idx] + ip2_arr[grant_idx];
    assign next_ptr = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);

    always_comb begin
        req_ready = '0;
        if (accept)
            req_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_out   <= '0;
            res_id    <= '0;
            rr_ptr    <= '0;
        end else if (accept) begin
            res_valid <= 1'b1;
            res_out   <= sum;
            res_id    <= grant_idx;
            rr_ptr    <= next_ptr;
        end else if (res_ready) begin
            // Drained with nothing new: data fields keep their last value.
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed scoreboard bench for adder_share_arbiter (N=32, NUM_REQ=4).
module tb_adder_share_arbiter;
    localparam int N = 32;
    localparam int NUM_REQ = 4;

    typedef struct packed {
        logic [1:0]   id;
        logic [N-1:0] sum;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*N-1:0] req_ip1, req_ip2;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 res_valid;
    logic [N-1:0]         res_out;
    logic [1:0]           res_id;
    logic                 res_ready;

    exp_t q[$];
    exp_t last_e;
    int compared = 0;
    int mismatched = 0;

    adder_share_arbiter #(.N(N), .NUM_REQ(NUM_REQ)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ip1(req_ip1),
        .req_ip2(req_ip2), .req_ready(req_ready), .res_valid(res_valid),
        .res_out(res_out), .res_id(res_id), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        req_ip1[i*N +: N] = a;
        req_ip2[i*N +: N] = b;
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic tick(input logic [NUM_REQ-1:0] exp_rdy, input string tag);
        logic pushed;
        exp_t e;
        pushed = 1'b0;
        #1;
        check({tag, "_ready"}, 64'(req_ready), 64'(exp_rdy));
        for (int i = 0; i < NUM_REQ; i++) begin
            if (exp_rdy[i]) begin
                e.id  = 2'(i);
                e.sum = req_ip1[i*N +: N] + req_ip2[i*N +: N];
                q.push_back(e);
                pushed = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (pushed) begin
            e = q.pop_front();
            check({tag, "_valid"}, 64'(res_valid), 64'(1));
            check({tag, "_sum"}, 64'(res_out), 64'(e.sum));
            check({tag, "_id"}, 64'(res_id), 64'(e.id));
            last_e = e;
        end
        @(negedge clk);
    endtask

    task automatic check_hold(input string tag, input logic exp_v);
        check({tag, "_valid"}, 64'(res_valid), 64'(exp_v));
        check({tag, "_sum"}, 64'(res_out), 64'(last_e.sum));
        check({tag, "_id"}, 64'(res_id), 64'(last_e.id));
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_ip1 = '0;
        req_ip2 = '0;
        res_ready = 1'b1;
        last_e = '0;
        #2;
        check("rst_valid", 64'(res_valid), 64'(0));
        check("rst_out", 64'(res_out), 64'(0));
        check("rst_id", 64'(res_id), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Single request from requester 2: 5 + 7.
        req_valid = 4'b0100;
        set_req(2, 32'd5, 32'd7);
        tick(4'b0100, "single");
        check("single_12", 64'(last_e.sum), 64'(12));

        // rr_ptr is 3 now: gapped pattern grants 0 then 2.
        req_valid = 4'b0101;
        set_req(0, 32'd100, 32'd23);
        tick(4'b0001, "gap0");
        set_req(2, 32'd40, 32'd2);
        tick(4'b0100, "gap2");

        // Modulo-2^N wrap on requester 3.
        req_valid = 4'b1000;
        set_req(3, 32'hFFFF_FFFF, 32'h0000_0002);
        tick(4'b1000, "wrap");
        check("wrap_one", 64'(last_e.sum), 64'(1));

        // Asynchronous reset while a result is held.
        check("pre_rst_valid", 64'(res_valid), 64'(1));
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(res_valid), 64'(0));
        check("arst_out", 64'(res_out), 64'(0));
        check("arst_id", 64'(res_id), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // All valid after reset: 0,1,2,3,0 back to back.
        req_valid = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'(i * 1000 + 1), 32'(i * 7 + 3));
        tick(4'b0001, "rr0");
        tick(4'b0010, "rr1");
        tick(4'b0100, "rr2");
        tick(4'b1000, "rr3");
        tick(4'b0001, "rr4");

        // Backpressure: nothing granted, result and pointer frozen.
        res_ready = 1'b0;
        req_valid = 4'b0011;
        set_req(0, 32'h1234_0000, 32'h0000_5678);
        set_req(1, 32'h8000_0000, 32'h8000_0001);
        for (int c = 0; c < 3; c++) begin
            tick(4'b0000, "bp");
            check_hold("bp_hold", 1'b1);
        end
        res_ready = 1'b1;
        tick(4'b0010, "bp_release");
        check("bp_release_sum", 64'(last_e.sum), 64'(1));

        // Drain with no request: valid drops, data fields hold.
        req_valid = '0;
        tick(4'b0000, "drain");
        check_hold("drain_hold", 1'b0);

        // Lone requester is granted every cycle.
        req_valid = 4'b0100;
        set_req(2, 32'd9, 32'd10);
        tick(4'b0100, "lone_a");
        set_req(2, 32'd20, 32'd22);
        tick(4'b0100, "lone_b");

        check("queue_empty", 64'(q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
